// File: rtl/bridge_read_arbiter.sv
// rtl/bridge_read_arbiter.sv - two-requester burst read arbiter in front of a single-beat bridge
module bridge_read_arbiter #(
    parameter int ADDR_BITS = 26,
    parameter int DATA_BITS = 128,
    parameter int LEN_BITS  = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [ADDR_BITS-1:0]   addr0,
    input  logic [ADDR_BITS-1:0]   addr1,
    input  logic [LEN_BITS-1:0]    len0,
    input  logic [LEN_BITS-1:0]    len1,
    output logic [1:0]             gnt,
    output logic [DATA_BITS-1:0]   rdata,
    output logic [1:0]             rvalid,
    output logic [1:0]             done,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [ADDR_BITS-1:0]   interface_address,
    output logic [DATA_BITS/8-1:0] interface_byte_enable,
    output logic                   interface_read,
    input  logic [DATA_BITS-1:0]   interface_read_data,
    input  logic                   interface_acknowledge
);

    localparam int STRIDE = DATA_BITS / 8;
    localparam int TW     = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} state_t;

    state_t              state;
    logic [LEN_BITS-1:0] remaining;
    logic [TW-1:0]       wait_cnt;
    logic                last;
    logic                owner;
    logic                pick;

    // On a tie the requester not served last wins; last resets to 1 so the first tie goes to 0.
    assign pick = (req0 && req1) ? ~last : req1;

    assign busy                  = (state != IDLE);
    assign interface_byte_enable = {(DATA_BITS/8){interface_read}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            gnt               <= 2'b00;
            rdata             <= '0;
            rvalid            <= 2'b00;
            done              <= 2'b00;
            timeout_err       <= 1'b0;
            interface_address <= '0;
            interface_read    <= 1'b0;
            remaining         <= '0;
            wait_cnt          <= '0;
            last              <= 1'b1;
            owner             <= 1'b0;
        end else begin
            rvalid <= 2'b00;
            done   <= 2'b00;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner             <= pick;
                        gnt               <= pick ? 2'b10 : 2'b01;
                        interface_address <= pick ? addr1 : addr0;
                        remaining         <= pick ? len1 : len0;
                        wait_cnt          <= '0;
                        if ((pick ? len1 : len0) == '0) begin
                            state <= FIN;
                        end else begin
                            state          <= ISSUE;
                            interface_read <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (interface_acknowledge) begin
                        rdata             <= interface_read_data;
                        rvalid[owner]     <= 1'b1;
                        interface_read    <= 1'b0;
                        interface_address <= interface_address + ADDR_BITS'(STRIDE);
                        remaining         <= remaining - LEN_BITS'(1);
                        state             <= GAP;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        // Remaining beats are abandoned; the burst still closes through FIN.
                        interface_read <= 1'b0;
                        timeout_err    <= 1'b1;
                        state          <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                GAP: begin
                    wait_cnt <= '0;
                    if (remaining != '0) begin
                        interface_read <= 1'b1;
                        state          <= ISSUE;
                    end else begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    done[owner] <= 1'b1;
                    last        <= owner;
                    gnt         <= 2'b00;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
